// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register with optional 2-entry skid, flush, hold
// and a saturating stall-cycle counter.
module pipe_skid_reg #(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             hold,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cycles
);
  logic             m_valid, s_valid, m_valid_n, s_valid_n;
  logic [WIDTH-1:0] m_data, s_data, m_data_n, s_data_n;
  logic             acc_in, acc_out, stall;
  assign in_ready  = (SKID != 0) ? ~s_valid : (~m_valid | (out_ready & ~hold));
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = m_valid & out_ready & ~hold;
  assign stall     = m_valid & (~out_ready | hold);
  always_comb begin
    m_valid_n = m_valid;
    m_data_n  = m_data;
    s_valid_n = s_valid;
    s_data_n  = s_data;
    if (flush) begin
      m_valid_n = 1'b0;
      m_data_n  = '0;
      s_valid_n = 1'b0;
      s_data_n  = '0;
    end else if (SKID != 0 && s_valid) begin
      // in_ready is low while the skid is occupied, so only a drain can happen here
      if (acc_out) begin
        m_valid_n = 1'b1;
        m_data_n  = s_data;
        s_valid_n = 1'b0;
      end
    end else if (!m_valid || acc_out) begin
      m_valid_n = acc_in;
      m_data_n  = acc_in ? in_data : m_data;
    end else if (SKID != 0 && acc_in) begin
      s_valid_n = 1'b1;
      s_data_n  = in_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
    end else begin
      m_valid <= m_valid_n;
      m_data  <= m_data_n;
      s_valid <= s_valid_n;
      s_data  <= s_data_n;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cycles <= '0;
    else if (cnt_clr) stall_cycles <= '0;
    else if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random checks of a SKID=1 and a SKID=0 instance
// against queue-based reference models.
module tb_pipe_skid_reg;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_hold, a_flush, a_cnt_clr;
  logic [63:0] a_in_data, a_out_data;
  logic [31:0] a_stall;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hold, b_flush, b_cnt_clr;
  logic [7:0]  b_in_data, b_out_data;
  logic [3:0]  b_stall;
  pipe_skid_reg #(.WIDTH(64), .SKID(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready), .hold(a_hold),
    .flush(a_flush), .cnt_clr(a_cnt_clr), .stall_cycles(a_stall));
  pipe_skid_reg #(.WIDTH(8), .SKID(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready), .hold(b_hold),
    .flush(b_flush), .cnt_clr(b_cnt_clr), .stall_cycles(b_stall));
  logic [63:0] qa[$];
  logic [7:0]  qb[$];
  longint      cnta, cntb;
  bit          za, zb;
  int          errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step_a(input logic v, input logic [63:0] d, input logic ordy, input logic h,
                        input logic f, input logic c);
    logic rdy, ai, ao;
    a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_hold = h; a_flush = f; a_cnt_clr = c;
    #1;
    rdy = qa.size() < 2;
    chk("a_in_ready", a_in_ready, rdy);
    chk("a_out_valid", a_out_valid, qa.size() > 0);
    if (qa.size() > 0) chk("a_out_data", a_out_data, qa[0]);
    else if (za) chk("a_out_data_zero", a_out_data, 0);
    chk("a_stall", a_stall, cnta);
    ai = v & rdy;
    ao = (qa.size() > 0) & ordy & ~h;
    @(posedge clk);
    if (c) cnta = 0;
    else if (qa.size() > 0 && (!ordy || h) && cnta < 64'hffff_ffff) cnta++;
    if (f) begin qa.delete(); za = 1; end
    else begin
      if (ao) void'(qa.pop_front());
      if (ai) begin qa.push_back(d); za = 0; end
    end
    #1;
  endtask
  task automatic step_b(input logic v, input logic [7:0] d, input logic ordy, input logic h,
                        input logic f, input logic c);
    logic rdy, ai, ao;
    b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_hold = h; b_flush = f; b_cnt_clr = c;
    #1;
    rdy = (qb.size() == 0) || (ordy && !h);
    chk("b_in_ready", b_in_ready, rdy);
    chk("b_out_valid", b_out_valid, qb.size() > 0);
    if (qb.size() > 0) chk("b_out_data", b_out_data, qb[0]);
    else if (zb) chk("b_out_data_zero", b_out_data, 0);
    chk("b_stall", b_stall, cntb);
    ai = v & rdy;
    ao = (qb.size() > 0) & ordy & ~h;
    @(posedge clk);
    if (c) cntb = 0;
    else if (qb.size() > 0 && (!ordy || h) && cntb < 15) cntb++;
    if (f) begin qb.delete(); zb = 1; end
    else begin
      if (ao) void'(qb.pop_front());
      if (ai) begin qb.push_back(d); zb = 0; end
    end
    #1;
  endtask
  task automatic idle_inputs();
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0; a_hold = 0; a_flush = 0; a_cnt_clr = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_hold = 0; b_flush = 0; b_cnt_clr = 0;
  endtask
  initial begin
    reset = 1;
    idle_inputs();
    cnta = 0; cntb = 0; za = 1; zb = 1;
    #12;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_stall", a_stall, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_stall", b_stall, 0);
    @(posedge clk); #1;
    reset = 0;
    // streaming at full rate
    for (int i = 1; i <= 3; i++) step_a(1, 64'(i), 1, 0, 0, 0);
    repeat (2) step_a(0, 0, 1, 0, 0, 0);
    // backpressure fills main then skid
    step_a(1, 64'hA, 0, 0, 0, 0);
    step_a(1, 64'hB, 0, 0, 0, 0);
    step_a(1, 64'hBAD, 0, 0, 0, 0);
    step_a(0, 0, 1, 0, 0, 0);
    step_a(0, 0, 1, 0, 0, 0);
    step_a(0, 0, 1, 0, 0, 0);
    // hold overrides out_ready
    step_a(1, 64'hC, 1, 0, 0, 0);
    repeat (3) step_a(0, 0, 1, 1, 0, 0);
    step_a(0, 0, 1, 0, 0, 0);
    step_a(0, 0, 1, 0, 0, 0);
    // flush with both entries full and an input offered
    step_a(1, 64'h5, 0, 0, 0, 0);
    step_a(1, 64'h6, 0, 0, 0, 0);
    step_a(1, 64'h7, 0, 0, 1, 0);
    step_a(0, 0, 1, 0, 0, 0);
    // flush coinciding with delivery and acceptance, then flush under hold
    step_a(1, 64'h8, 0, 0, 0, 0);
    step_a(1, 64'h9, 1, 0, 1, 0);
    step_a(1, 64'hE, 0, 0, 0, 0);
    step_a(0, 0, 1, 1, 1, 0);
    step_a(0, 0, 1, 0, 0, 1);
    step_a(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step_a($urandom_range(3) != 0, {$urandom, $urandom}, $urandom_range(1) == 1,
             $urandom_range(3) == 0, $urandom_range(31) == 0, $urandom_range(31) == 0);
    // asynchronous reset with main and skid occupied
    step_a(1, 64'h11, 0, 0, 0, 0);
    step_a(1, 64'h22, 0, 0, 0, 0);
    idle_inputs();
    #2 reset = 1;
    #1;
    chk("mid_rst_out_valid", a_out_valid, 0);
    chk("mid_rst_out_data", a_out_data, 0);
    chk("mid_rst_stall", a_stall, 0);
    chk("mid_rst_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    reset = 0;
    qa.delete(); qb.delete(); cnta = 0; cntb = 0; za = 1; zb = 1;
    step_a(0, 0, 1, 0, 0, 0);
    // SKID=0: in_ready tracks out_ready when full, then counter saturation
    step_b(1, 8'h31, 0, 0, 0, 0);
    step_b(0, 0, 0, 0, 0, 0);
    step_b(1, 8'h32, 1, 0, 0, 0);
    step_b(0, 0, 1, 1, 0, 0);
    repeat (20) step_b(0, 0, 0, 0, 0, 0);
    chk("b_saturated", b_stall, 15);
    step_b(0, 0, 0, 0, 0, 1);
    step_b(0, 0, 1, 0, 0, 0);
    step_b(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step_b($urandom_range(3) != 0, 8'($urandom), $urandom_range(1) == 1,
             $urandom_range(3) == 0, $urandom_range(31) == 0, $urandom_range(31) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
